joy_responder: RTL

Serial joystick responder: the device side of the two-pad shift-register joystick link. It presents two 8-bit pad states, `joy1` and `joy2`, on the serial `joyD` line. The line is driven by the `joyCk`, `joyLd` and `joyS` strobes from the console-side joystick reader. It stands in for the external 74HC165-style pad hardware, either as a pad adapter on boards without native pads or as the bench model for the reader. All strobes are oversampled and synchronised in the system clock domain.

---
 rtl/joy_responder.sv | 101 ++++++++++
 1 files changed

// File: rtl/joy_responder.sv
// Device side of the two-pad serial joystick link: snapshots joy1/joy2 on load
// and shifts them out MSB-first, active-low, on joyCk rising edges.
module joy_responder #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             joyCk,
    input  logic             joyLd,
    input  logic             joyS,
    input  logic [WIDTH-1:0] joy1,
    input  logic [WIDTH-1:0] joy2,
    output logic             joyD,
    output logic             frame,
    output logic             busy
);
    localparam int FLEN = 2 * WIDTH;
    localparam int CW   = $clog2(FLEN) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    // Bit 1 is the synchronised level, bit 2 the delayed copy for edge detection.
    logic [2:0]      ck_sync_q;
    logic [2:0]      ld_sync_q;
    logic [1:0]      s_sync_q;
    logic [FLEN-1:0] sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    state_t          state_q, state_d;
    logic            joyd_q;
    logic            frame_q, frame_d;

    logic ck_s, ld_s, s_s, ck_rise, ld_fall, shift;

    assign ck_s    = ck_sync_q[1];
    assign ld_s    = ld_sync_q[1];
    assign s_s     = s_sync_q[1];
    assign ck_rise = ck_s & ~ck_sync_q[2];
    assign ld_fall = ~ld_s & ld_sync_q[2];
    // Load has priority: clock edges seen while loading are discarded.
    assign shift   = ck_rise & ~ld_s;

    always_comb begin
        sr_d = sr_q;
        if (ld_s)
            sr_d = s_s ? ~{joy2, joy1} : ~{joy1, joy2};
        else if (ck_rise)
            sr_d = {sr_q[FLEN-2:0], 1'b1};
    end

    always_comb begin
        cnt_d = cnt_q;
        if (ld_fall)
            cnt_d = '0;
        else if (shift && (cnt_q < CW'(FLEN)))
            cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        frame_d = 1'b0;
        case (state_q)
            IDLE: if (ld_s) state_d = LOAD;
            LOAD: if (ld_fall) state_d = SHIFT;
            SHIFT: begin
                if (ld_s) begin
                    state_d = LOAD;
                end else if (shift && (cnt_q == CW'(FLEN - 1))) begin
                    state_d = IDLE;
                    frame_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ck_sync_q <= '0;
            ld_sync_q <= '0;
            s_sync_q  <= '0;
            sr_q      <= '1;
            cnt_q     <= CW'(FLEN);
            state_q   <= IDLE;
            joyd_q    <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            ck_sync_q <= {ck_sync_q[1:0], joyCk};
            ld_sync_q <= {ld_sync_q[1:0], joyLd};
            s_sync_q  <= {s_sync_q[0], joyS};
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            joyd_q    <= sr_q[FLEN-1];
            frame_q   <= frame_d;
        end
    end

    assign joyD  = joyd_q;
    assign frame = frame_q;
    assign busy  = (state_q == SHIFT);
endmodule
